// File: rtl/accum_frame_add_sub.sv
// Framed add/sub accumulator: sums exactly LEN accepted samples per frame with sticky carry/overflow flags.
// Define ACCUM_SATURATE_EN to clamp S on signed overflow instead of wrapping.
module accum_frame_add_sub #(
  parameter int unsigned N   = 8,
  parameter int unsigned LEN = 4,
  parameter int unsigned CW  = $clog2(LEN + 1)
) (
  input  logic         clk,
  input  logic         aclr,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic         add_sub,
  output logic [N-1:0] A_reg_out,
  output logic [N-1:0] S,
  output logic         S_valid,
  output logic         done,
  output logic         busy,
  output logic         carry,
  output logic         overflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic          as_q, as_d;
  logic          pv_q, pv_d;
  logic [CW-1:0] acc_cnt_q, acc_cnt_d;
  logic [CW-1:0] sum_cnt_q, sum_cnt_d;
  logic [N-1:0]  s_q, s_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          s_valid_q, s_valid_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;

  logic [N-1:0]  b_op;
  logic [N:0]    add_full;
  logic          carry_c;
  logic          ovf_c;
  logic [N-1:0]  res;

  // Stage-2 adder; subtraction is S + ~A + 1, so the operand sign test covers both modes.
  always_comb begin
    b_op     = as_q ? ~a_q : a_q;
    add_full = {1'b0, s_q} + {1'b0, b_op} + (N + 1)'(as_q);
    carry_c  = as_q ^ add_full[N];
    ovf_c    = (s_q[N-1] == b_op[N-1]) && (add_full[N-1] != s_q[N-1]);
`ifdef ACCUM_SATURATE_EN
    // On overflow the true result has the sign of S.
    if (ovf_c) res = s_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else       res = add_full[N-1:0];
`else
    res = add_full[N-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    as_d      = as_q;
    pv_d      = pv_q;
    acc_cnt_d = acc_cnt_q;
    sum_cnt_d = sum_cnt_q;
    s_d       = s_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    s_valid_d = s_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ACCUM;
          s_d       = '0;
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          s_valid_d = 1'b0;
          acc_cnt_d = '0;
          sum_cnt_d = '0;
          pv_d      = 1'b0;
        end
      end
      ST_ACCUM: begin
        pv_d = 1'b0;
        if (in_valid && ready_q) begin
          a_d       = A;
          as_d      = add_sub;
          pv_d      = 1'b1;
          acc_cnt_d = acc_cnt_q + CW'(1);
        end
        if (pv_q) begin
          s_d       = res;
          carry_d   = carry_q | carry_c;
          ovf_d     = ovf_q | ovf_c;
          sum_cnt_d = sum_cnt_q + CW'(1);
          if (sum_cnt_q == CW'(LEN - 1)) begin
            state_d   = ST_DONE;
            s_valid_d = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered from the next-state view so they align with state_q.
    ready_d = (state_d == ST_ACCUM) && (acc_cnt_d < CW'(LEN));
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      as_q      <= 1'b0;
      pv_q      <= 1'b0;
      acc_cnt_q <= '0;
      sum_cnt_q <= '0;
      s_q       <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      s_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      as_q      <= as_d;
      pv_q      <= pv_d;
      acc_cnt_q <= acc_cnt_d;
      sum_cnt_q <= sum_cnt_d;
      s_q       <= s_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      s_valid_q <= s_valid_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign in_ready  = ready_q;
  assign A_reg_out = a_q;
  assign S         = s_q;
  assign S_valid   = s_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_accum_frame_add_sub.sv
// Bench for accum_frame_add_sub: directed frames, expected results queued and checked on each done pulse.
module tb_accum_frame_add_sub;

  logic       clk = 1'b0;
  logic       aclr;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic       add_sub;
  logic [7:0] A_reg_out;
  logic [7:0] S;
  logic       S_valid;
  logic       done;
  logic       busy;
  logic       carry;
  logic       overflow;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done_prev = 1'b0;

  accum_frame_add_sub #(.N(8), .LEN(4)) dut (
    .clk(clk), .aclr(aclr), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .add_sub(add_sub), .A_reg_out(A_reg_out), .S(S), .S_valid(S_valid),
    .done(done), .busy(busy), .carry(carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse consumes one queued frame result.
  always @(negedge clk) begin
    if (done) begin
      check("done_one_cycle", 32'(done_prev), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no frame pending at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("frame_S", 32'(S), 32'(e.s));
        check("frame_carry", 32'(carry), 32'(e.c));
        check("frame_overflow", 32'(overflow), 32'(e.o));
        check("frame_S_valid", 32'(S_valid), 32'd1);
      end
    end
    done_prev = done;
  end

  task automatic push(input logic [7:0] s, input logic c, input logic o);
    exp_t e;
    e.s = s; e.c = c; e.o = o;
    sb.push_back(e);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge just after the acceptance edge.
  task automatic send(input logic [7:0] a, input logic as);
    int budget;
    in_valid = 1'b1;
    A        = a;
    add_sub  = as;
    budget   = 20;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 at %0t", $time);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Last sample was just accepted: accumulation edge next, then DONE for one cycle.
  task automatic finish_frame();
    in_valid = 1'b0;
    @(negedge clk);
    check("done_latency", 32'(done), 32'd1);
    @(negedge clk);
    check("done_cleared", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("S_valid_held", 32'(S_valid), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_A_reg_out"}, 32'(A_reg_out), 32'd0);
    check({tag, "_S"}, 32'(S), 32'd0);
    check({tag, "_S_valid"}, 32'(S_valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_carry"}, 32'(carry), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [7:0] sat_exp;
    aclr = 1'b1; start = 1'b0; in_valid = 1'b0; A = '0; add_sub = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    aclr = 1'b0;
    @(negedge clk);

    // 1: plain add frame
    push(8'h64, 1'b0, 1'b0);
    do_start();
    check("start_S_valid", 32'(S_valid), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd1);
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0); send(8'd40, 1'b0);
    finish_frame();
    check("t1_A_reg_out", 32'(A_reg_out), 32'd40);
    idle(3);
    check("t1_S_hold", 32'(S), 32'h64);
    check("t1_S_valid_hold", 32'(S_valid), 32'd1);

    // 2: signed overflow on add
`ifdef ACCUM_SATURATE_EN
    sat_exp = 8'h7F;
`else
    sat_exp = 8'h96;
`endif
    push(sat_exp, 1'b0, 1'b1);
    do_start();
    send(8'd100, 1'b0); send(8'd50, 1'b0); send(8'd0, 1'b0); send(8'd0, 1'b0);
    finish_frame();

    // 3: subtract with borrow
    push(8'hEC, 1'b1, 1'b0);
    do_start();
    check("t3_S_cleared", 32'(S), 32'd0);
    check("t3_overflow_cleared", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) send(8'd5, 1'b1);
    finish_frame();

    // 4: gaps between samples
    push(8'h0A, 1'b0, 1'b0);
    do_start();
    for (int i = 1; i <= 4; i++) begin
      send(8'(i), 1'b0);
      if (i < 4) begin
        idle(2);
        check("t4_ready_mid", 32'(in_ready), 32'd1);
      end
    end
    check("t4_ready_after_last", 32'(in_ready), 32'd0);
    finish_frame();

    // 5: abort with aclr, then IDLE ignores in_valid
    do_start();
    send(8'd1, 1'b0); send(8'd2, 1'b0);
    in_valid = 1'b0;
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    check_all_zero("abort");
    in_valid = 1'b1; A = 8'd99;
    repeat (3) @(negedge clk);
    check("t5_idle_ready", 32'(in_ready), 32'd0);
    check("t5_idle_A_reg", 32'(A_reg_out), 32'd0);
    check("t5_idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    push(8'h04, 1'b0, 1'b0);
    do_start();
    for (int i = 0; i < 4; i++) send(8'd1, 1'b0);
    finish_frame();

    // 6: start during ACCUM and in_valid in IDLE are ignored
    push(8'h22, 1'b0, 1'b0);
    do_start();
    send(8'd7, 1'b0); send(8'd8, 1'b0);
    in_valid = 1'b0;
    do_start();
    check("t6_busy", 32'(busy), 32'd1);
    send(8'd9, 1'b0); send(8'd10, 1'b0);
    finish_frame();
    in_valid = 1'b1; A = 8'h55;
    repeat (3) @(negedge clk);
    check("t6_A_reg_hold", 32'(A_reg_out), 32'd10);
    check("t6_S_hold", 32'(S), 32'h22);
    check("t6_S_valid_hold", 32'(S_valid), 32'd1);
    check("t6_idle_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

endmodule
